// File: rtl/cart_pkg.sv
// Shared types and constants for the two-port cart bus arbiter.
package cart_pkg;

  localparam int NUM_PORTS = 2;

  // Value returned on a read that was abandoned by the bus timeout.
  localparam logic [7:0] RD_FILL = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_END,
    DONE
  } state_t;

  // One latched requester transaction.
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        is_write;
  } req_t;

endpackage

// File: rtl/cart_req_latch.sv
// Per-port request latch: accepts one transaction while idle, reports it
// as pending until the arbiter core takes it, holds busy until the core
// completes it and keeps the last read data.
module cart_req_latch
  import cart_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [7:0]  din,
  input  logic        rd,
  input  logic        wr,
  input  logic        take,
  input  logic        done,
  input  logic        load,
  input  logic [7:0]  load_val,
  output logic        busy,
  output logic        pending,
  output req_t        rec,
  output logic [7:0]  dout
);

  // Accept while idle (rd+wr together counts as a write), hand off, complete.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy    <= 1'b0;
      pending <= 1'b0;
      rec     <= '0;
      dout    <= '0;
    end else begin
      if (!busy && (rd || wr)) begin
        busy    <= 1'b1;
        pending <= 1'b1;
        rec     <= '{addr: addr, data: din, is_write: wr};
      end else begin
        if (take) pending <= 1'b0;
        if (done) busy    <= 1'b0;
      end
      if (load) dout <= load_val;
    end
  end

endmodule

// File: rtl/cart_arbiter.sv
// Two-requester arbiter in front of a single cart bus master port.
// Optional bus timeout with sticky err output: define CART_ARB_TIMEOUT_EN.
module cart_arbiter
  import cart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int RR_EN          = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a_addr,
  input  logic [7:0]  a_din,
  input  logic        a_rd,
  input  logic        a_wr,
  output logic [7:0]  a_dout,
  output logic        a_busy,
  input  logic [15:0] b_addr,
  input  logic [7:0]  b_din,
  input  logic        b_rd,
  input  logic        b_wr,
  output logic [7:0]  b_dout,
  output logic        b_busy,
  output logic [15:0] m_addr,
  output logic [7:0]  m_din,
  output logic        m_rd,
  output logic        m_wr,
  input  logic [7:0]  m_dout,
  input  logic        m_busy
`ifdef CART_ARB_TIMEOUT_EN
  ,
  output logic        err
`endif
);

  logic [NUM_PORTS-1:0][15:0] p_addr;
  logic [NUM_PORTS-1:0][7:0]  p_din;
  logic [NUM_PORTS-1:0][7:0]  p_dout;
  logic [NUM_PORTS-1:0]       p_rd, p_wr, busy, pending, take, done, load;
  req_t [NUM_PORTS-1:0]       rec;

  state_t     state;
  logic       gnt;       // port owning the current transaction
  logic       rr_ptr;    // port preferred on the next contended arbitration
  logic       sel;
  logic [7:0] load_val;
  logic       tmo_fire;
  logic       timed_out;

  assign p_addr = {b_addr, a_addr};
  assign p_din  = {b_din, a_din};
  assign p_rd   = {b_rd, a_rd};
  assign p_wr   = {b_wr, a_wr};
  assign a_busy = busy[0];
  assign b_busy = busy[1];
  assign a_dout = p_dout[0];
  assign b_dout = p_dout[1];

  assign load_val = timed_out ? RD_FILL : m_dout;

  // Grant select: contention resolved by rr_ptr, or A when fixed priority.
  always_comb begin
    sel = 1'b0;
    if (pending[0] && pending[1]) sel = (RR_EN != 0) ? rr_ptr : 1'b0;
    else if (pending[1])          sel = 1'b1;
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign take[p] = (state == IDLE) && (|pending) && (sel == 1'(p));
    assign done[p] = (state == DONE) && (gnt == 1'(p));
    assign load[p] = done[p] && !rec[p].is_write;

    cart_req_latch u_latch (
      .clk      (clk),
      .rst      (rst),
      .addr     (p_addr[p]),
      .din      (p_din[p]),
      .rd       (p_rd[p]),
      .wr       (p_wr[p]),
      .take     (take[p]),
      .done     (done[p]),
      .load     (load[p]),
      .load_val (load_val),
      .busy     (busy[p]),
      .pending  (pending[p]),
      .rec      (rec[p]),
      .dout     (p_dout[p])
    );
  end

  // Arbitration, one-cycle strobe, m_busy handshake and completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      gnt    <= 1'b0;
      rr_ptr <= 1'b0;
      m_rd   <= 1'b0;
      m_wr   <= 1'b0;
      m_addr <= '0;
      m_din  <= '0;
    end else begin
      case (state)
        IDLE: if (|pending) begin
          gnt    <= sel;
          m_addr <= rec[sel].addr;
          m_din  <= rec[sel].data;
          m_rd   <= !rec[sel].is_write;
          m_wr   <= rec[sel].is_write;
          state  <= ISSUE;
        end
        ISSUE: begin
          m_rd  <= 1'b0;
          m_wr  <= 1'b0;
          state <= WAIT_START;
        end
        WAIT_START: begin
          if (m_busy)        state <= WAIT_END;
          else if (tmo_fire) state <= DONE;
        end
        WAIT_END: if (!m_busy || tmo_fire) state <= DONE;
        DONE: begin
          rr_ptr <= ~gnt;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_cnt;
  logic          waiting, progress;

  assign waiting  = (state == WAIT_START) || (state == WAIT_END);
  // A state that is about to advance normally never times out that cycle.
  assign progress = (state == WAIT_START) ? m_busy : !m_busy;
  assign tmo_fire = waiting && !progress && (wait_cnt >= CW'(TIMEOUT_CYCLES - 1));

  // Wait-cycle counter, sticky err and the fill-data marker for DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt  <= '0;
      err       <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      if (state == ISSUE)
        wait_cnt <= '0;
      else if (waiting && wait_cnt != CW'(TIMEOUT_CYCLES))
        wait_cnt <= wait_cnt + 1'b1;
      if (tmo_fire) begin
        err       <= 1'b1;
        timed_out <= 1'b1;
      end else if (state == DONE) begin
        timed_out <= 1'b0;
      end
    end
  end
`else
  logic unused_tmo;
  assign tmo_fire   = 1'b0;
  assign timed_out  = 1'b0;
  assign unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_cart_arbiter.sv
// Directed bench for cart_arbiter: a round-robin instance (dut) and a
// fixed-priority instance (fdut), each behind a small cart bus model.
module tb_cart_arbiter;
  import cart_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] a_addr, b_addr, m_addr;
  logic [7:0]  a_din, b_din, a_dout, b_dout, m_din, m_dout;
  logic        a_rd, a_wr, b_rd, b_wr, a_busy, b_busy, m_rd, m_wr, m_busy;

  logic [15:0] fa_addr, fb_addr, fm_addr;
  logic [7:0]  fa_din, fb_din, fa_dout, fb_dout, fm_din, fm_dout;
  logic        fa_rd, fa_wr, fb_rd, fb_wr, fa_busy, fb_busy, fm_rd, fm_wr, fm_busy;
`ifdef CART_ARB_TIMEOUT_EN
  logic err, f_err;
`endif

  cart_arbiter #(.TIMEOUT_CYCLES(16), .RR_EN(1)) dut (
    .clk(clk), .rst(rst),
    .a_addr(a_addr), .a_din(a_din), .a_rd(a_rd), .a_wr(a_wr), .a_dout(a_dout), .a_busy(a_busy),
    .b_addr(b_addr), .b_din(b_din), .b_rd(b_rd), .b_wr(b_wr), .b_dout(b_dout), .b_busy(b_busy),
    .m_addr(m_addr), .m_din(m_din), .m_rd(m_rd), .m_wr(m_wr), .m_dout(m_dout), .m_busy(m_busy)
`ifdef CART_ARB_TIMEOUT_EN
    , .err(err)
`endif
  );

  cart_arbiter #(.TIMEOUT_CYCLES(16), .RR_EN(0)) fdut (
    .clk(clk), .rst(rst),
    .a_addr(fa_addr), .a_din(fa_din), .a_rd(fa_rd), .a_wr(fa_wr), .a_dout(fa_dout), .a_busy(fa_busy),
    .b_addr(fb_addr), .b_din(fb_din), .b_rd(fb_rd), .b_wr(fb_wr), .b_dout(fb_dout), .b_busy(fb_busy),
    .m_addr(fm_addr), .m_din(fm_din), .m_rd(fm_rd), .m_wr(fm_wr), .m_dout(fm_dout), .m_busy(fm_busy)
`ifdef CART_ARB_TIMEOUT_EN
    , .err(f_err)
`endif
  );

  // Cart model: m_busy rises the edge after a strobe, lasts busy_len cycles
  // (or forever while hang is set); reads return addr[7:0].
  int busy_len = 1;
  bit hang = 1'b0;
  int m_left, fm_left;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0; m_dout <= '0; m_left <= 0;
    end else if (m_rd || m_wr) begin
      m_busy <= 1'b1; m_left <= busy_len - 1;
      if (m_rd) m_dout <= m_addr[7:0];
    end else if (m_busy && !hang) begin
      if (m_left == 0) m_busy <= 1'b0;
      else m_left <= m_left - 1;
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fm_busy <= 1'b0; fm_dout <= '0; fm_left <= 0;
    end else if (fm_rd || fm_wr) begin
      fm_busy <= 1'b1; fm_left <= 0;
      if (fm_rd) fm_dout <= fm_addr[7:0];
    end else if (fm_busy) begin
      fm_busy <= 1'b0;
    end
  end

  // Strobe monitor: cycles of m_rd/m_wr and the addresses in issue order.
  int          rd_cnt, wr_cnt;
  logic [15:0] rd_log[$];
  logic [15:0] f_log[$];
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;

  always @(negedge clk) begin
    if (m_rd) begin rd_cnt++; rd_log.push_back(m_addr); end
    if (m_wr) begin wr_cnt++; wr_addr = m_addr; wr_data = m_din; end
    if (fm_rd) f_log.push_back(fm_addr);
  end

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic clear_mon();
    rd_cnt = 0; wr_cnt = 0; rd_log.delete(); f_log.delete();
  endtask

  task automatic wait_free(output int cyc);
    cyc = 0;
    while ((a_busy || b_busy || fa_busy || fb_busy) && cyc < 200) begin
      @(negedge clk); cyc++;
    end
  endtask

  task automatic test_reset();
    tot_cnt++; if ({a_busy, b_busy, m_rd, m_wr} !== 4'b0) $display("FAIL reset_ctl: got %b expected 0000", {a_busy, b_busy, m_rd, m_wr}); else pass_cnt++;
    tot_cnt++; if ({a_dout, b_dout} !== 16'h0) $display("FAIL reset_dout: got %h expected 0000", {a_dout, b_dout}); else pass_cnt++;
    tot_cnt++; if ({m_addr, m_din} !== 24'h0) $display("FAIL reset_bus: got %h expected 000000", {m_addr, m_din}); else pass_cnt++;
`ifdef CART_ARB_TIMEOUT_EN
    tot_cnt++; if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else pass_cnt++;
`endif
    @(negedge clk); rst = 1'b1;
    clear_mon();
    repeat (4) @(negedge clk);
    tot_cnt++; if (rd_cnt + wr_cnt !== 0) $display("FAIL reset_quiet: got %0d strobes expected 0", rd_cnt + wr_cnt); else pass_cnt++;
  endtask

  task automatic test_single_read();
    int lat;
    clear_mon();
    @(negedge clk); a_addr = 16'h1234; a_rd = 1'b1;
    @(negedge clk); a_rd = 1'b0;
    tot_cnt++; if (a_busy !== 1'b1) $display("FAIL rd_busy_set: got %b expected 1", a_busy); else pass_cnt++;
    lat = 0;
    while (a_busy && lat < 50) begin @(negedge clk); lat++; end
    tot_cnt++; if (lat !== 5) $display("FAIL rd_latency: got %0d expected 5", lat); else pass_cnt++;
    tot_cnt++; if (rd_cnt !== 1 || wr_cnt !== 0) $display("FAIL rd_pulse: got rd=%0d wr=%0d expected rd=1 wr=0", rd_cnt, wr_cnt); else pass_cnt++;
    tot_cnt++; if ((rd_log.size() == 1 ? rd_log[0] : 16'hxxxx) !== 16'h1234) $display("FAIL rd_addr: got %h expected 1234", (rd_log.size() > 0) ? rd_log[0] : 16'hxxxx); else pass_cnt++;
    tot_cnt++; if (a_dout !== 8'h34) $display("FAIL rd_dout: got %h expected 34", a_dout); else pass_cnt++;
    tot_cnt++; if (m_addr !== 16'h1234) $display("FAIL rd_addr_hold: got %h expected 1234", m_addr); else pass_cnt++;
  endtask

  task automatic test_write();
    int cyc;
    clear_mon();
    @(negedge clk); b_addr = 16'h2000; b_din = 8'hA5; b_wr = 1'b1;
    @(negedge clk); b_wr = 1'b0;
    wait_free(cyc);
    tot_cnt++; if (b_busy !== 1'b0) $display("FAIL wr_done: got busy %b expected 0", b_busy); else pass_cnt++;
    tot_cnt++; if (wr_cnt !== 1 || rd_cnt !== 0) $display("FAIL wr_pulse: got wr=%0d rd=%0d expected wr=1 rd=0", wr_cnt, rd_cnt); else pass_cnt++;
    tot_cnt++; if ({wr_addr, wr_data} !== 24'h2000A5) $display("FAIL wr_bus: got %h expected 2000a5", {wr_addr, wr_data}); else pass_cnt++;
    tot_cnt++; if (b_dout !== 8'h00) $display("FAIL wr_dout: got %h expected 00", b_dout); else pass_cnt++;
    // rd and wr together is a write and leaves a_dout alone
    clear_mon();
    @(negedge clk); a_addr = 16'h3000; a_din = 8'h5A; a_rd = 1'b1; a_wr = 1'b1;
    @(negedge clk); a_rd = 1'b0; a_wr = 1'b0;
    wait_free(cyc);
    tot_cnt++; if (wr_cnt !== 1 || rd_cnt !== 0) $display("FAIL rdwr_is_wr: got wr=%0d rd=%0d expected wr=1 rd=0", wr_cnt, rd_cnt); else pass_cnt++;
    tot_cnt++; if ({a_dout, wr_data} !== 16'h345A) $display("FAIL rdwr_data: got %h expected 345a", {a_dout, wr_data}); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int cyc;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    clear_mon();
    @(negedge clk); a_addr = 16'h0001; a_rd = 1'b1; b_addr = 16'h0002; b_rd = 1'b1;
    @(negedge clk); a_rd = 1'b0; b_rd = 1'b0;
    wait_free(cyc);
    tot_cnt++; if ((rd_log.size() == 2 ? {rd_log[0], rd_log[1]} : 32'hx) !== 32'h0001_0002) $display("FAIL rr_first_order: got %0d strobes expected A then B", rd_log.size()); else pass_cnt++;
    tot_cnt++; if ({a_dout, b_dout} !== 16'h0102) $display("FAIL rr_first_dout: got %h expected 0102", {a_dout, b_dout}); else pass_cnt++;
    // A served alone, so the next contended pair must go to B first
    @(negedge clk); a_addr = 16'h0010; a_rd = 1'b1;
    @(negedge clk); a_rd = 1'b0;
    wait_free(cyc);
    clear_mon();
    @(negedge clk); a_addr = 16'h0003; a_rd = 1'b1; b_addr = 16'h0004; b_rd = 1'b1;
    @(negedge clk); a_rd = 1'b0; b_rd = 1'b0;
    wait_free(cyc);
    tot_cnt++; if ((rd_log.size() == 2 ? {rd_log[0], rd_log[1]} : 32'hx) !== 32'h0004_0003) $display("FAIL rr_second_order: got %0d strobes expected B then A", rd_log.size()); else pass_cnt++;
    tot_cnt++; if ({a_dout, b_dout} !== 16'h0304) $display("FAIL rr_second_dout: got %h expected 0304", {a_dout, b_dout}); else pass_cnt++;
  endtask

  task automatic test_fixed_priority();
    int cyc, n;
    clear_mon();
    @(negedge clk); fa_addr = 16'h0100; fa_rd = 1'b1; fb_addr = 16'h0200; fb_rd = 1'b1;
    @(negedge clk); fa_rd = 1'b0; fb_rd = 1'b0;
    n = 0;
    while (fa_busy && n < 50) begin @(negedge clk); n++; end
    // A re-requests the cycle its busy falls; B is already waiting
    fa_addr = 16'h0101; fa_rd = 1'b1;
    @(negedge clk); fa_rd = 1'b0;
    wait_free(cyc);
    tot_cnt++; if ((f_log.size() == 3 ? {f_log[0], f_log[1], f_log[2]} : 48'hx) !== 48'h0100_0200_0101) $display("FAIL fp_b2b_order: got %0d strobes expected A,B,A", f_log.size()); else pass_cnt++;
    tot_cnt++; if ({fa_dout, fb_dout} !== 16'h0100) $display("FAIL fp_b2b_dout: got %h expected 0100", {fa_dout, fb_dout}); else pass_cnt++;
    // after a lone A, a contended pair still goes to A first
    @(negedge clk); fa_addr = 16'h0102; fa_rd = 1'b1;
    @(negedge clk); fa_rd = 1'b0;
    wait_free(cyc);
    clear_mon();
    @(negedge clk); fa_addr = 16'h0103; fa_rd = 1'b1; fb_addr = 16'h0203; fb_rd = 1'b1;
    @(negedge clk); fa_rd = 1'b0; fb_rd = 1'b0;
    wait_free(cyc);
    tot_cnt++; if ((f_log.size() == 2 ? {f_log[0], f_log[1]} : 32'hx) !== 32'h0103_0203) $display("FAIL fp_pair_order: got %0d strobes expected A then B", f_log.size()); else pass_cnt++;
  endtask

`ifdef CART_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    clear_mon();
    hang = 1'b1;
    @(negedge clk); a_addr = 16'h0042; a_rd = 1'b1;
    @(negedge clk); a_rd = 1'b0;
    n = 0;
    while (!err && n < 40) begin @(negedge clk); n++; end
    // WAIT_START is entered two edges after acceptance
    tot_cnt++; if (err !== 1'b1 || n > 18) $display("FAIL tmo_err: got err=%b after %0d cycles expected 1 within 18", err, n); else pass_cnt++;
    n = 0;
    while (a_busy && n < 10) begin @(negedge clk); n++; end
    tot_cnt++; if (a_busy !== 1'b0) $display("FAIL tmo_release: got busy %b expected 0", a_busy); else pass_cnt++;
    tot_cnt++; if (a_dout !== 8'hFF) $display("FAIL tmo_dout: got %h expected ff", a_dout); else pass_cnt++;
    tot_cnt++; if (dut.state !== IDLE) $display("FAIL tmo_state: got %0d expected %0d", dut.state, IDLE); else pass_cnt++;
    hang = 1'b0;
    repeat (3) @(negedge clk);
    tot_cnt++; if (err !== 1'b1) $display("FAIL tmo_sticky: got %b expected 1", err); else pass_cnt++;
  endtask
`endif

  task automatic test_reset_mid();
    busy_len = 10;
    clear_mon();
    @(negedge clk); a_addr = 16'h00AA; b_addr = 16'h0; a_rd = 1'b1;
    @(negedge clk); a_rd = 1'b0;
    repeat (4) @(negedge clk);  // cart busy, arbiter in WAIT_END
    tot_cnt++; if ({a_busy, m_busy} !== 2'b11) $display("FAIL mid_inflight: got %b expected 11", {a_busy, m_busy}); else pass_cnt++;
    rst = 1'b0;
    #1;
    tot_cnt++; if ({a_busy, b_busy, m_rd, m_wr, m_addr, m_din} !== 28'h0) $display("FAIL mid_rst_bus: got %h expected 0", {a_busy, b_busy, m_rd, m_wr, m_addr, m_din}); else pass_cnt++;
    tot_cnt++; if ({a_dout, b_dout} !== 16'h0) $display("FAIL mid_rst_dout: got %h expected 0000", {a_dout, b_dout}); else pass_cnt++;
`ifdef CART_ARB_TIMEOUT_EN
    tot_cnt++; if (err !== 1'b0) $display("FAIL mid_rst_err: got %b expected 0", err); else pass_cnt++;
`endif
    busy_len = 1;
    @(negedge clk); rst = 1'b1;
    clear_mon();
    repeat (20) @(negedge clk);
    tot_cnt++; if (rd_cnt + wr_cnt !== 0) $display("FAIL mid_no_reissue: got %0d strobes expected 0", rd_cnt + wr_cnt); else pass_cnt++;
    tot_cnt++; if (a_busy !== 1'b0) $display("FAIL mid_busy_after: got %b expected 0", a_busy); else pass_cnt++;
  endtask

  initial begin
    a_addr = '0; a_din = '0; a_rd = 1'b0; a_wr = 1'b0;
    b_addr = '0; b_din = '0; b_rd = 1'b0; b_wr = 1'b0;
    fa_addr = '0; fa_din = '0; fa_rd = 1'b0; fa_wr = 1'b0;
    fb_addr = '0; fb_din = '0; fb_rd = 1'b0; fb_wr = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_single_read();
    test_write();
    test_round_robin();
    test_fixed_priority();
`ifdef CART_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
